// File: rtl/correction_mq_pkg.sv
// Shared types and helpers for the multi-multiple final-correction stage.
// Optional range flag: CORRECTION_MQ_RANGE_CHECK_EN.
package correction_mq_pkg;

    typedef struct packed {
        logic ff_in;
        logic ff_sub;
        logic ff_out;
    } correction_mq_params_t;

    function automatic int correction_mq_lat(correction_mq_params_t p);
        return int'(p.ff_in) + int'(p.ff_sub) + int'(p.ff_out);
    endfunction

    function automatic int correction_mq_logc(int logq, int nmul);
        return logq + $clog2(nmul);
    endfunction

endpackage

// File: rtl/correction_mq_if.sv
// Valid/ready bus of the correction stage: operand side and result side.
// err exists only with CORRECTION_MQ_RANGE_CHECK_EN.
interface correction_mq_if #(
    parameter int LOGQ  = 64,
    parameter int LOGQH = 17,
    parameter int LOGC  = 66
);
    logic [LOGQH-1:0] qH;
    logic [LOGC-1:0]  C;
    logic             in_valid;
    logic             in_ready;
    logic [LOGQ-1:0]  T;
    logic             out_valid;
    logic             out_ready;
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
    logic             err;
`endif

    modport master (
        output qH, C, in_valid, out_ready,
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
        input  err,
`endif
        input  in_ready, T, out_valid
    );

    modport slave (
        input  qH, C, in_valid, out_ready,
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
        output err,
`endif
        output in_ready, T, out_valid
    );

endinterface

// File: rtl/correction_mq_cand.sv
// One candidate D_J = C - J*q with a borrow MSB.
// J*q is a constant shift-add of q; no multiplier.
module correction_mq_cand #(
    parameter int LOGQ = 64,
    parameter int LOGC = 66,
    parameter int J    = 0
) (
    input  logic [LOGC-1:0] c_i,
    input  logic [LOGQ-1:0] q_i,
    output logic [LOGC:0]   d_o
);
    localparam int JB = $clog2(J + 1) + 1;

    logic [LOGC:0] jq;

    // sum of q shifted by every set bit of the constant J
    always_comb begin
        jq = '0;
        for (int b = 0; b < JB; b++) begin
            if (((J >> b) & 1) != 0) begin
                jq = jq + ((LOGC + 1)'(q_i) << b);
            end
        end
    end

    assign d_o = {1'b0, c_i} - jq;

endmodule

// File: rtl/correction_mq.sv
// Final correction: T = C mod q for C < NMUL*q, q = {qH, 0..0, 1}.
// Optional err flag for C >= NMUL*q: CORRECTION_MQ_RANGE_CHECK_EN.
module correction_mq
    import correction_mq_pkg::*;
#(
    parameter int LOGQ   = 64,
    parameter int LOGQH  = 17,
    parameter int NMUL   = 4,
    parameter int LOGC   = correction_mq_logc(LOGQ, NMUL),
    parameter int FF_IN  = 1,
    parameter int FF_SUB = 1,
    parameter int FF_OUT = 1
) (
    input  logic           clk,
    input  logic           rst,
    correction_mq_if.slave bus
);
    localparam int W = LOGQ - LOGQH;
    localparam correction_mq_params_t P = '{
        ff_in:  (FF_IN != 0),
        ff_sub: (FF_SUB != 0),
        ff_out: (FF_OUT != 0)
    };
    localparam int LAT = correction_mq_lat(P);

    logic en;

    logic [LOGC-1:0]  c_s1;
    logic [LOGQH-1:0] qh_s1;
    logic             v_s1;

    logic [LOGQ-1:0]             q;
    logic [NMUL-1:0]             bor_c;
    logic [NMUL-1:0][LOGQ-1:0]   low_c;

    logic [NMUL-1:0]             bor_s2;
    logic [NMUL-1:0][LOGQ-1:0]   low_s2;
    logic                        v_s2;

    int                          sel_cnt;
    logic [LOGQ-1:0]             t_sel;

    logic [LOGQ-1:0]             t_s3;
    logic                        v_s3;

`ifdef CORRECTION_MQ_RANGE_CHECK_EN
    logic err_c;
    logic err_s2;
    logic err_s3;
`endif

    // a full output register that is not being drained freezes the pipe
    assign en           = !v_s3 || bus.out_ready;
    assign bus.in_ready = (LAT == 0) ? bus.out_ready : en;

    // input stage
    if (FF_IN != 0) begin : g_in
        logic [LOGC-1:0]  c_q;
        logic [LOGQH-1:0] qh_q;
        logic             v_q;

        // capture operands on every advance
        always_ff @(posedge clk) begin
            if (rst) begin
                c_q  <= '0;
                qh_q <= '0;
                v_q  <= 1'b0;
            end else if (en) begin
                c_q  <= bus.C;
                qh_q <= bus.qH;
                v_q  <= bus.in_valid;
            end
        end

        assign c_s1  = c_q;
        assign qh_s1 = qh_q;
        assign v_s1  = v_q;
    end else begin : g_in_c
        assign c_s1  = bus.C;
        assign qh_s1 = bus.qH;
        assign v_s1  = bus.in_valid;
    end

    if (W > 0) begin : g_q
        assign q = (LOGQ'(qh_s1) << W) | LOGQ'(1);
    end else begin : g_q0
        assign q = LOGQ'(qh_s1);
    end

    for (genvar j = 0; j < NMUL; j++) begin : g_cand
        logic [LOGC:0] d;
        logic          unused_hi;

        correction_mq_cand #(
            .LOGQ(LOGQ),
            .LOGC(LOGC),
            .J   (j)
        ) u_cand (
            .c_i(c_s1),
            .q_i(q),
            .d_o(d)
        );

        assign bor_c[j]  = d[LOGC];
        assign low_c[j]  = d[LOGQ-1:0];
        assign unused_hi = ^d[LOGC-1:LOGQ];
    end

`ifdef CORRECTION_MQ_RANGE_CHECK_EN
    logic [LOGC:0] d_top;
    logic          unused_top;

    correction_mq_cand #(
        .LOGQ(LOGQ),
        .LOGC(LOGC),
        .J   (NMUL)
    ) u_cand_top (
        .c_i(c_s1),
        .q_i(q),
        .d_o(d_top)
    );

    assign unused_top = ^d_top[LOGC-1:0];
    assign err_c      = !bor_c[NMUL-1] && !d_top[LOGC];
`endif

    // subtraction stage
    if (FF_SUB != 0) begin : g_sub
        logic [NMUL-1:0]           bor_q;
        logic [NMUL-1:0][LOGQ-1:0] low_q;
        logic                      v_q;
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
        logic                      err_q;
`endif

        // register every candidate's borrow and low bits
        always_ff @(posedge clk) begin
            if (rst) begin
                bor_q <= '0;
                low_q <= '0;
                v_q   <= 1'b0;
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
                err_q <= 1'b0;
`endif
            end else if (en) begin
                bor_q <= bor_c;
                low_q <= low_c;
                v_q   <= v_s1;
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
                err_q <= err_c;
`endif
            end
        end

        assign bor_s2 = bor_q;
        assign low_s2 = low_q;
        assign v_s2   = v_q;
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
        assign err_s2 = err_q;
`endif
    end else begin : g_sub_c
        assign bor_s2 = bor_c;
        assign low_s2 = low_c;
        assign v_s2   = v_s1;
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
        assign err_s2 = err_c;
`endif
    end

    // candidates shrink with j, so k = (#non-negative) - 1 is the answer
    always_comb begin
        sel_cnt = 0;
        t_sel   = low_s2[0];
        for (int j = 0; j < NMUL; j++) begin
            sel_cnt = sel_cnt + int'(!bor_s2[j]);
        end
        for (int j = 0; j < NMUL; j++) begin
            if (j == sel_cnt - 1) begin
                t_sel = low_s2[j];
            end
        end
    end

    // output stage
    if (FF_OUT != 0) begin : g_out
        logic [LOGQ-1:0] t_q;
        logic            v_q;
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
        logic            err_q;
`endif

        // hold the result until the consumer takes it
        always_ff @(posedge clk) begin
            if (rst) begin
                t_q   <= '0;
                v_q   <= 1'b0;
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
                err_q <= 1'b0;
`endif
            end else if (en) begin
                t_q   <= t_sel;
                v_q   <= v_s2;
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
                err_q <= err_s2;
`endif
            end
        end

        assign t_s3 = t_q;
        assign v_s3 = v_q;
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
        assign err_s3 = err_q;
`endif
    end else begin : g_out_c
        assign t_s3 = t_sel;
        assign v_s3 = v_s2;
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
        assign err_s3 = err_s2;
`endif
    end

    assign bus.T         = t_s3;
    assign bus.out_valid = v_s3;
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
    assign bus.err       = err_s3;
`endif

endmodule

// File: tb/tb_correction_mq.sv
// Directed bench: q = 177 (qH = 4'b1011, LOGQ = 8), NMUL = 4.
// One pipelined DUT (all FF = 1) and one combinational DUT (all FF = 0).
module tb_correction_mq;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    correction_mq_if #(.LOGQ(8), .LOGQH(4), .LOGC(10)) if1 ();
    correction_mq_if #(.LOGQ(8), .LOGQH(4), .LOGC(10)) if0 ();

    correction_mq #(
        .LOGQ(8), .LOGQH(4), .NMUL(4), .LOGC(10),
        .FF_IN(1), .FF_SUB(1), .FF_OUT(1)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(if1)
    );

    correction_mq #(
        .LOGQ(8), .LOGQH(4), .NMUL(4), .LOGC(10),
        .FF_IN(0), .FF_SUB(0), .FF_OUT(0)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] qh, input logic [9:0] c,
                         input logic v);
        if1.qH = qh;
        if1.C = c;
        if1.in_valid = v;
        if0.qH = qh;
        if0.C = c;
        if0.in_valid = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'd0, 10'd0, 1'b0);
        if1.out_ready = 1'b1;
        if0.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (if1.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid got %b want 0", if1.out_valid);
        end
        n_cmp++;
        if (if1.T !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_T got %0d want 0", if1.T);
        end
        n_cmp++;
        if (if1.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready got %b want 1", if1.in_ready);
        end
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
        n_cmp++;
        if (if1.err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_err got %b want 0", if1.err);
        end
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [3:0] qh_t [9] = '{4'd11, 4'd11, 4'd11, 4'd11, 4'd11,
                                4'd11, 4'd11, 4'd0, 4'd0};
        logic [9:0] c_t  [9] = '{10'd100, 10'd177, 10'd359, 10'd530,
                                10'd0, 10'd531, 10'd707, 10'd3, 10'd2};
        logic [7:0] t_t  [9] = '{8'd100, 8'd0, 8'd5, 8'd176,
                                8'd0, 8'd0, 8'd176, 8'd0, 8'd0};
        int lat;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(qh_t[i], c_t[i], 1'b1);
            #1;
            n_cmp++;
            if (if0.out_valid !== 1'b1 || if0.T !== t_t[i]) begin
                n_bad++;
                $display("FAIL vec%0d_comb got v=%b T=%0d want v=1 T=%0d",
                         i, if0.out_valid, if0.T, t_t[i]);
            end
            lat = 0;
            do begin
                @(negedge clk);
                drive(4'd11, 10'd0, 1'b0);
                lat++;
                #1;
                if (lat == 1) begin
                    n_cmp++;
                    if (if0.out_valid !== 1'b0) begin
                        n_bad++;
                        $display("FAIL vec%0d_comb_idle got %b want 0",
                                 i, if0.out_valid);
                    end
                end
            end while (if1.out_valid !== 1'b1 && lat < 10);
            n_cmp++;
            if (lat != 3) begin
                n_bad++;
                $display("FAIL vec%0d_latency got %0d want 3", i, lat);
            end
            n_cmp++;
            if (if1.T !== t_t[i]) begin
                n_bad++;
                $display("FAIL vec%0d_T got %0d want %0d", i, if1.T, t_t[i]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_range();
        logic [9:0] c_t [2] = '{10'd708, 10'd707};
        logic [7:0] t_t [2] = '{8'd177, 8'd176};
        logic       e_t [2] = '{1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(4'd11, c_t[i], 1'b1);
            #1;
            n_cmp++;
            if (if0.T !== t_t[i]) begin
                n_bad++;
                $display("FAIL range%0d_comb got %0d want %0d",
                         i, if0.T, t_t[i]);
            end
            lat = 0;
            do begin
                @(negedge clk);
                drive(4'd11, 10'd0, 1'b0);
                lat++;
                #1;
            end while (if1.out_valid !== 1'b1 && lat < 10);
            n_cmp++;
            if (lat != 3 || if1.T !== t_t[i]) begin
                n_bad++;
                $display("FAIL range%0d_T got T=%0d lat=%0d want T=%0d lat=3",
                         i, if1.T, lat, t_t[i]);
            end
`ifdef CORRECTION_MQ_RANGE_CHECK_EN
            n_cmp++;
            if (if1.err !== e_t[i]) begin
                n_bad++;
                $display("FAIL range%0d_err got %b want %b",
                         i, if1.err, e_t[i]);
            end
`else
            if (e_t[i] === 1'bx) $display("range flag absent");
`endif
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [9:0] stim [50];
        logic [7:0] exp_q [$];
        logic [7:0] e;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        for (int i = 0; i < 50; i++) stim[i] = 10'($urandom_range(707, 0));
        while (got < 50 && cyc < 200) begin
            @(negedge clk);
            if (sent < 50) drive(4'd11, stim[sent], 1'b1);
            else drive(4'd11, 10'd0, 1'b0);
            #1;
            if (sent < 50) begin
                e = 8'(stim[sent] % 177);
                n_cmp++;
                if (if0.out_valid !== 1'b1 || if0.T !== e) begin
                    n_bad++;
                    $display("FAIL b2b_comb%0d got T=%0d want %0d",
                             sent, if0.T, e);
                end
            end
            if (if1.out_valid === 1'b1 && if1.out_ready === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_extra got T=%0d want none", if1.T);
                end else begin
                    e = exp_q.pop_front();
                    if (if1.T !== e) begin
                        n_bad++;
                        $display("FAIL b2b_T%0d got %0d want %0d",
                                 got, if1.T, e);
                    end
                end
                got++;
            end
            if (if1.in_valid === 1'b1 && if1.in_ready === 1'b1) begin
                exp_q.push_back(8'(stim[sent] % 177));
                sent++;
            end
            cyc++;
        end
        n_cmp++;
        if (got != 50 || cyc != 53) begin
            n_bad++;
            $display("FAIL b2b_rate got %0d results in %0d cycles want 50 in 53",
                     got, cyc);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stall();
        logic [9:0] stim [20];
        logic [7:0] exp_q [$];
        logic [7:0] e;
        logic [7:0] held_t;
        logic       held;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        held = 1'b0;
        held_t = '0;
        for (int i = 0; i < 20; i++) stim[i] = 10'((i * 37 + 11) % 708);
        while (got < 20 && cyc < 200) begin
            @(negedge clk);
            if1.out_ready = !(cyc >= 6 && cyc < 11);
            if (sent < 20) drive(4'd11, stim[sent], 1'b1);
            else drive(4'd11, 10'd0, 1'b0);
            #1;
            n_cmp++;
            if (if1.in_ready !== if1.out_ready) begin
                n_bad++;
                $display("FAIL stall_in_ready cyc%0d got %b want %b",
                         cyc, if1.in_ready, if1.out_ready);
            end
            if (held) begin
                n_cmp++;
                if (if1.out_valid !== 1'b1 || if1.T !== held_t) begin
                    n_bad++;
                    $display("FAIL stall_hold cyc%0d got v=%b T=%0d want v=1 T=%0d",
                             cyc, if1.out_valid, if1.T, held_t);
                end
            end
            held = (if1.out_valid === 1'b1) && !if1.out_ready;
            held_t = if1.T;
            if (if1.out_valid === 1'b1 && if1.out_ready === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stall_extra got T=%0d want none", if1.T);
                end else begin
                    e = exp_q.pop_front();
                    if (if1.T !== e) begin
                        n_bad++;
                        $display("FAIL stall_T%0d got %0d want %0d",
                                 got, if1.T, e);
                    end
                end
                got++;
            end
            if (if1.in_valid === 1'b1 && if1.in_ready === 1'b1) begin
                exp_q.push_back(8'(stim[sent] % 177));
                sent++;
            end
            cyc++;
        end
        n_cmp++;
        if (got != 20) begin
            n_bad++;
            $display("FAIL stall_count got %0d want 20", got);
        end
        if1.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (if1.out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_dup cyc%0d got %b want 0", i, if1.out_valid);
            end
        end
    endtask

    task automatic test_reset_flight();
        logic [9:0] c_t [3] = '{10'd100, 10'd359, 10'd530};
        if1.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(4'd11, c_t[i], 1'b1);
        end
        @(negedge clk);
        drive(4'd11, 10'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (if1.out_valid !== 1'b0 || if1.T !== 8'd0) begin
            n_bad++;
            $display("FAIL rstfl_clear got v=%b T=%0d want v=0 T=0",
                     if1.out_valid, if1.T);
        end
        n_cmp++;
        if (if1.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rstfl_in_ready got %b want 1", if1.in_ready);
        end
        rst = 1'b0;
        if1.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (if1.out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rstfl_stale cyc%0d got v=%b T=%0d want v=0",
                         i, if1.out_valid, if1.T);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_vectors();
        test_range();
        test_back_to_back();
        test_stall();
        test_reset_flight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/correction_mq.md
# correction_mq

Final-correction stage for the Montgomery multiplier, generalised from single conditional subtraction to multi-multiple reduction. It accepts an input C in [0, NMUL·q), with q = {qH, 0…0, 1} of special form. It returns T = C mod q using NMUL parallel candidate subtractions and a priority select. It sits after the reduction datapath when lazy reduction leaves C up to NMUL·q, and uses a valid/ready handshake with backpressure so that it can drive stalling consumers.

## Interface
- LOGQ, 64: modulus width in bits.
- LOGQH, 17: width of qH, the upper modulus bits; W = LOGQ − LOGQH low bits are 0…01.
- NMUL, 4: exclusive bound multiple, so C < NMUL·q; ≥ 2.
- LOGC, LOGQ + $clog2(NMUL): input width.
- FF_IN, 1: register at the input stage.
- FF_SUB, 1: register after the candidate subtractions.
- FF_OUT, 1: register at the output.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- qH  in  LOGQH  upper modulus bits; sampled with C and carried down the pipeline.
- C  in  LOGC  value to reduce.
- in_valid  in  1  C and qH are valid.
- in_ready  out  1  the block accepts input this cycle.
- T  out  LOGQ  the reduced result.
- out_valid  out  1  T is valid.
- out_ready  in  1  the consumer accepts T.
- err  out  1  out of range; present only with CORRECTION_MQ_RANGE_CHECK_EN.

## Operation
- Modulus: q = {qH, {(W−1){0}}, 1} when W > 0; otherwise q = qH.
- Candidates:
  - D_j = C − j·q for j = 0…NMUL−1, each computed in LOGC+1 bits; the MSB is the borrow.
  - j·q is formed by shift-add from q, with no general multiplier.
- Select: k = (number of D_j with MSB = 0) − 1; T = D_k[LOGQ−1:0].
  - The D_j decrease monotonically, so k is the largest non-negative index.
  - D_0 is always non-negative.
- Enabled stages: each enabled stage (FF_IN, FF_SUB, FF_OUT) holds data plus a valid bit.
  - The FF_SUB stage registers all D_j borrow bits and the selected low LOGQ bits of every D_j.
  - The priority mux may sit before or after FF_SUB, but the latency is fixed.
- Handshake:
  - Global advance en = !out_valid || out_ready.
  - in_ready = en.
  - A transfer occurs when in_valid && in_ready on the input side, or when out_valid && out_ready on the output side.
  - When en = 0, every stage holds data and valid.
- Bubbles: these propagate normally. The pipeline does not compact them; a stall freezes the whole pipe.
- Reset:
  - All valid bits clear to 0 and all data registers clear to 0.
  - out_valid = 0, T = 0, err = 0, in_ready = 1 in the cycle after rst is sampled high.
- Reset mid-operation: in-flight transactions are discarded and none emerge afterwards.
- Boundaries:
  - C = j·q gives T = 0.
  - C = NMUL·q − 1 gives T = q − 1.
  - qH = 0 with W > 0 gives q = 1, so T = 0 for any C < NMUL.

## Timing
- Latency: LAT = FF_IN + FF_SUB + FF_OUT cycles from input transfer to out_valid when out_ready is held high.
- LAT = 0: the block is fully combinational. out_valid = in_valid, in_ready = out_ready, and rst has no effect on outputs.
- Throughput: one result per cycle with no stall.
- Stall: a result presented with out_ready = 0 holds T and err stable until it is accepted.

## Configuration
- CORRECTION_MQ_RANGE_CHECK_EN
  - Defined: the err port exists. err = (MSB of D_{NMUL−1} = 0 and C − NMUL·q ≥ 0), meaning C ≥ NMUL·q. err is pipelined alongside T.
  - On err, T = D_{NMUL−1}[LOGQ−1:0].
  - Undefined: the err port and its logic are absent. An out-of-range C yields the same T, unflagged.

## Structure
- Package correction_mq_pkg holds:
  - correction_mq_params_t, a packed {FF_IN, FF_SUB, FF_OUT}.
  - The function correction_mq_lat(params), which sums the flags.
  - The function correction_mq_logc(LOGQ, NMUL).
- Sub-module correction_mq_cand(LOGC, J) computes D_J from C and q (shift-add J·q, then subtract). It is instantiated NMUL times in a generate loop.

## Test plan
- LOGQ=8, LOGQH=4, NMUL=4, qH=4'b1011 (q=177), all FF=1, out_ready=1:
  - C=100 → T=100.
  - C=177 → T=0.
  - C=359 → T=5.
  - C=530 → T=176.
  - Each arrives 3 cycles after input.
- Back-to-back stream of 50 random C < 708: one result per cycle, in order, each T = C mod 177.
- out_ready low for 5 cycles mid-stream:
  - in_ready follows out_ready.
  - T is held stable.
  - No loss or duplication after release.
- rst asserted with 3 transactions in flight: out_valid=0 and T=0 next cycle; no stale result appears afterwards.
- With RANGE_CHECK_EN, C=708 → err=1 and T=177; C=707 → err=0 and T=176.
- All FF=0: same vectors produce combinational same-cycle results, and out_valid = in_valid.
